// File: rtl/osd_trace_packetization_mc_pkg.sv
// DII flit type plus the trace packetizer's shared constants, sizing helpers and FSM states.
// The TSTAMP state only exists when OSD_TRACE_TIMESTAMP_EN is defined.
package dii_package;

  typedef struct packed {
    logic [15:0] data;
    logic        valid;
    logic        last;
  } dii_flit;

endpackage

package osd_trace_package;

  localparam logic [1:0] TYPE_TRACE  = 2'h2;
  localparam logic       STATUS_MARK = 1'b1;

  // Payload flits needed to carry one trace word of the given width.
  function automatic int num_flits(input int width);
    return (width + 15) / 16;
  endfunction

  // Zero bits padded into the top of the final payload flit.
  function automatic int fill_last(input int width);
    return num_flits(width) * 16 - width;
  endfunction

  typedef enum logic [2:0] {
    IDLE,
    SOURCE,
`ifdef OSD_TRACE_TIMESTAMP_EN
    TSTAMP,
`endif
    STATUS,
    EVENT
  } state_t;

endpackage

// File: rtl/osd_trace_packetization_mc_if.sv
// DII output port: one flit (data/valid/last) towards the sink, ready back from it.
interface osd_trace_packetization_mc_if;
  import dii_package::*;

  dii_flit flit;
  logic    ready;

  modport master (output flit, input ready);
  modport slave  (input flit, output ready);
endinterface

// File: rtl/osd_trace_packetization_mc_rr_arbiter.sv
// Combinational round-robin pick: first requesting channel at or after ptr, wrapping.
module osd_trace_rr_arbiter #(
  parameter int NUM_CHANNELS = 2
) (
  input  logic [NUM_CHANNELS-1:0] req,
  input  logic [1:0]              ptr,
  output logic                    any,
  output logic [1:0]              pick
);

  logic [3:0]                    req_pad;
  logic [NUM_CHANNELS-1:0][1:0]  idx_at;
  logic [NUM_CHANNELS-1:0]       req_rot;

  assign req_pad = 4'(req);

  // idx_at[gi] is the channel sitting gi places after the pointer.
  for (genvar gi = 0; gi < NUM_CHANNELS; gi++) begin : g_off
    logic [2:0] sum;
    assign sum         = {1'b0, ptr} + 3'(gi);
    assign idx_at[gi]  = (sum >= 3'(NUM_CHANNELS)) ? 2'(sum - 3'(NUM_CHANNELS)) : sum[1:0];
    assign req_rot[gi] = req_pad[idx_at[gi]];
  end

  always_comb begin
    pick = 2'd0;
    for (int i = NUM_CHANNELS - 1; i >= 0; i--) begin
      if (req_rot[i]) pick = idx_at[i];
    end
  end

  assign any = |req;

endmodule

// File: rtl/osd_trace_packetization_mc.sv
// Multi-channel trace packetizer: round-robin over trace sources, one DII packet per word.
// Define OSD_TRACE_TIMESTAMP_EN to add a 32-bit cycle timestamp (two flits) after the header.
module osd_trace_packetization_mc
  import osd_trace_package::*;
  import dii_package::*;
#(
  parameter int WIDTH        = 32,
  parameter int NUM_CHANNELS = 2
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [9:0]                      id,
  input  logic [15:0]                     dest,
  input  logic [NUM_CHANNELS*WIDTH-1:0]   trace_data,
  input  logic [NUM_CHANNELS-1:0]         trace_overflow,
  input  logic [NUM_CHANNELS-1:0]         trace_valid,
  output logic [NUM_CHANNELS-1:0]         trace_ready,
  osd_trace_packetization_mc_if.master    debug_out
);

  localparam int NF   = num_flits(WIDTH);
  localparam int PADW = WIDTH + fill_last(WIDTH);
  localparam int CW   = $clog2(NF + 1);

  state_t          state_reg, state_next;
  logic [CW-1:0]   cnt_reg, cnt_next;
  logic [1:0]      grant_reg, grant_next;
  logic [1:0]      rr_ptr_reg, rr_ptr_next;
  logic            ovf_reg, ovf_next;

  logic            arb_any;
  logic [1:0]      arb_pick;
  logic [3:0]      ovf_pad;
  logic [PADW-1:0] ch_word [4];
  logic [PADW-1:0] word;
  logic            hs;
  logic            last_hs;
  logic            flit_valid;
  logic            flit_last;
  logic [15:0]     flit_data;
  dii_flit         flit_out;

`ifdef OSD_TRACE_TIMESTAMP_EN
  logic [31:0]     ts_cnt_reg;
  logic [31:0]     ts_reg;
  logic            ts_capture;
`endif

  osd_trace_rr_arbiter #(
    .NUM_CHANNELS(NUM_CHANNELS)
  ) u_arbiter (
    .req  (trace_valid),
    .ptr  (rr_ptr_reg),
    .any  (arb_any),
    .pick (arb_pick)
  );

  // Unused channel slots read as zero so grant can always index a 4-entry table.
  for (genvar gi = 0; gi < 4; gi++) begin : g_word
    if (gi < NUM_CHANNELS) begin : g_used
      assign ch_word[gi] = PADW'(trace_data[gi*WIDTH +: WIDTH]);
    end else begin : g_unused
      assign ch_word[gi] = '0;
    end
  end

  for (genvar gi = 0; gi < NUM_CHANNELS; gi++) begin : g_ready
    assign trace_ready[gi] = last_hs && (grant_reg == 2'(gi));
  end

  assign ovf_pad = 4'(trace_overflow);
  assign word    = ch_word[grant_reg];
  assign hs      = debug_out.ready;

  always_comb begin
    state_next  = state_reg;
    cnt_next    = cnt_reg;
    grant_next  = grant_reg;
    rr_ptr_next = rr_ptr_reg;
    ovf_next    = ovf_reg;
    flit_valid  = 1'b0;
    flit_last   = 1'b0;
    flit_data   = 16'h0000;
    last_hs     = 1'b0;
`ifdef OSD_TRACE_TIMESTAMP_EN
    ts_capture  = 1'b0;
`endif

    case (state_reg)
      IDLE: begin
        if (arb_any) begin
          flit_valid = 1'b1;
          flit_data  = dest;
          if (hs) begin
            grant_next = arb_pick;
            state_next = SOURCE;
`ifdef OSD_TRACE_TIMESTAMP_EN
            ts_capture = 1'b1;
`endif
          end
        end
      end

      SOURCE: begin
        flit_valid = 1'b1;
        flit_data  = {TYPE_TRACE, grant_reg, ovf_pad[grant_reg], 1'b0, id};
        if (hs) begin
          ovf_next = ovf_pad[grant_reg];
          cnt_next = '0;
`ifdef OSD_TRACE_TIMESTAMP_EN
          state_next = TSTAMP;
`else
          state_next = ovf_pad[grant_reg] ? STATUS : EVENT;
`endif
        end
      end

`ifdef OSD_TRACE_TIMESTAMP_EN
      TSTAMP: begin
        flit_valid = 1'b1;
        flit_data  = (cnt_reg == '0) ? ts_reg[15:0] : ts_reg[31:16];
        if (hs) begin
          if (cnt_reg == CW'(1)) begin
            cnt_next   = '0;
            state_next = ovf_reg ? STATUS : EVENT;
          end else begin
            cnt_next = cnt_reg + CW'(1);
          end
        end
      end
`endif

      STATUS: begin
        flit_valid = 1'b1;
        flit_last  = 1'b1;
        flit_data  = {STATUS_MARK, 5'h00, word[9:0]};
        if (hs) begin
          last_hs     = 1'b1;
          rr_ptr_next = (grant_reg == 2'(NUM_CHANNELS - 1)) ? 2'd0 : grant_reg + 2'd1;
          state_next  = IDLE;
        end
      end

      EVENT: begin
        flit_valid = 1'b1;
        flit_last  = (cnt_reg == CW'(NF - 1));
        flit_data  = word[{cnt_reg, 4'b0000} +: 16];
        if (hs) begin
          if (cnt_reg == CW'(NF - 1)) begin
            last_hs     = 1'b1;
            rr_ptr_next = (grant_reg == 2'(NUM_CHANNELS - 1)) ? 2'd0 : grant_reg + 2'd1;
            state_next  = IDLE;
          end else begin
            cnt_next = cnt_reg + CW'(1);
          end
        end
      end

      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= IDLE;
      cnt_reg    <= '0;
      grant_reg  <= 2'd0;
      rr_ptr_reg <= 2'd0;
      ovf_reg    <= 1'b0;
    end else begin
      state_reg  <= state_next;
      cnt_reg    <= cnt_next;
      grant_reg  <= grant_next;
      rr_ptr_reg <= rr_ptr_next;
      ovf_reg    <= ovf_next;
    end
  end

`ifdef OSD_TRACE_TIMESTAMP_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ts_cnt_reg <= 32'h0;
      ts_reg     <= 32'h0;
    end else begin
      ts_cnt_reg <= ts_cnt_reg + 32'h1;
      if (ts_capture) ts_reg <= ts_cnt_reg;
    end
  end
`endif

  // Gating with rst_n forces valid/last low for the whole reset, even mid-packet.
  always_comb begin
    flit_out.data  = flit_data;
    flit_out.valid = flit_valid & rst_n;
    flit_out.last  = flit_last & rst_n;
  end

  assign debug_out.flit = flit_out;

endmodule

// File: tb/tb_osd_trace_packetization_mc.sv
// Directed bench for osd_trace_packetization_mc: a 32-bit and a 20-bit instance, 2 channels each.
// Inputs change on the falling edge; outputs are sampled 1 time unit later.
module tb_osd_trace_packetization_mc;

  logic        clk;
  logic        rst_n;

  logic [63:0] a_data;
  logic [1:0]  a_ovf, a_valid, a_ready;
  logic [39:0] b_data;
  logic [1:0]  b_ovf, b_valid, b_ready;

  int vectors;
  int miscompares;

  osd_trace_packetization_mc_if ia ();
  osd_trace_packetization_mc_if ib ();

  osd_trace_packetization_mc #(.WIDTH(32), .NUM_CHANNELS(2)) dut32 (
    .clk            (clk),
    .rst_n          (rst_n),
    .id             (10'h155),
    .dest           (16'h1234),
    .trace_data     (a_data),
    .trace_overflow (a_ovf),
    .trace_valid    (a_valid),
    .trace_ready    (a_ready),
    .debug_out      (ia)
  );

  osd_trace_packetization_mc #(.WIDTH(20), .NUM_CHANNELS(2)) dut20 (
    .clk            (clk),
    .rst_n          (rst_n),
    .id             (10'h0AA),
    .dest           (16'h4321),
    .trace_data     (b_data),
    .trace_overflow (b_ovf),
    .trace_valid    (b_valid),
    .trace_ready    (b_ready),
    .debug_out      (ib)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic do_reset;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset;
    @(negedge clk);
    rst_n    = 1'b0;
    a_valid  = 2'b11;
    ia.ready = 1'b1;
    #1;
    vectors++;
    if (ia.flit.valid !== 1'b0 || ia.flit.last !== 1'b0 || a_ready !== 2'b00) begin
      miscompares++;
      $display("FAIL reset: got valid=%b last=%b ready=%b, want 0 0 00",
               ia.flit.valid, ia.flit.last, a_ready);
    end else $display("reset: outputs idle");
    @(negedge clk);
    a_valid = 2'b00;
    rst_n   = 1'b1;
    #1;
    vectors++;
    if (ia.flit.valid !== 1'b0 || ib.flit.valid !== 1'b0 || b_ready !== 2'b00) begin
      miscompares++;
      $display("FAIL reset_release: got a_valid=%b b_valid=%b b_ready=%b, want 0 0 00",
               ia.flit.valid, ib.flit.valid, b_ready);
    end else $display("reset_release: idle with no requests");
  endtask

  task automatic test_single;
    logic [15:0] exp_d [4] = '{16'h1234, 16'h8155, 16'hBEEF, 16'hDEAD};
    @(negedge clk);
    a_data  = 64'h0000_0000_DEAD_BEEF;
    a_valid = 2'b01;
    for (int k = 0; k < 4; k++) begin
      #1;
      vectors++;
      if (ia.flit.valid !== 1'b1 || ia.flit.data !== exp_d[k] ||
          ia.flit.last !== 1'(k == 3) || a_ready !== ((k == 3) ? 2'b01 : 2'b00)) begin
        miscompares++;
        $display("FAIL single_flit%0d: got v=%b d=%h l=%b rdy=%b, want v=1 d=%h l=%b rdy=%b",
                 k, ia.flit.valid, ia.flit.data, ia.flit.last, a_ready,
                 exp_d[k], (k == 3), (k == 3) ? 2'b01 : 2'b00);
      end else $display("single_flit%0d: d=%h", k, ia.flit.data);
      @(negedge clk);
    end
    a_valid = 2'b00;
    #1;
    vectors++;
    if (ia.flit.valid !== 1'b0) begin
      miscompares++;
      $display("FAIL single_idle: got valid=%b, want 0", ia.flit.valid);
    end else $display("single_idle: back to idle");
  endtask

  task automatic test_width20;
    logic [15:0] exp_d [4] = '{16'h4321, 16'h90AA, 16'hBCDE, 16'h000A};
    @(negedge clk);
    b_data  = {20'hABCDE, 20'h00000};
    b_ovf   = 2'b00;
    b_valid = 2'b10;
    ib.ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #1;
      vectors++;
      if (ib.flit.valid !== 1'b1 || ib.flit.data !== exp_d[k] ||
          ib.flit.last !== 1'(k == 3) || b_ready !== ((k == 3) ? 2'b10 : 2'b00)) begin
        miscompares++;
        $display("FAIL w20_flit%0d: got v=%b d=%h l=%b rdy=%b, want v=1 d=%h l=%b rdy=%b",
                 k, ib.flit.valid, ib.flit.data, ib.flit.last, b_ready,
                 exp_d[k], (k == 3), (k == 3) ? 2'b10 : 2'b00);
      end else $display("w20_flit%0d: d=%h", k, ib.flit.data);
      @(negedge clk);
    end
    b_valid = 2'b00;
  endtask

  task automatic test_back_to_back;
    logic [15:0] exp_d;
    logic        exp_l;
    logic [1:0]  exp_r;
    int          g;
    do_reset();
    @(negedge clk);
    a_data  = 64'h3333_4444_1111_2222;
    a_ovf   = 2'b00;
    a_valid = 2'b11;
    ia.ready = 1'b1;
    for (int p = 0; p < 4; p++) begin
      g = p % 2;
      for (int k = 0; k < 4; k++) begin
        case (k)
          0:       exp_d = 16'h1234;
          1:       exp_d = (g == 0) ? 16'h8155 : 16'h9155;
          2:       exp_d = (g == 0) ? 16'h2222 : 16'h4444;
          default: exp_d = (g == 0) ? 16'h1111 : 16'h3333;
        endcase
        exp_l = (k == 3);
        exp_r = (k == 3) ? ((g == 0) ? 2'b01 : 2'b10) : 2'b00;
        #1;
        vectors++;
        if (ia.flit.valid !== 1'b1 || ia.flit.data !== exp_d ||
            ia.flit.last !== exp_l || a_ready !== exp_r) begin
          miscompares++;
          $display("FAIL b2b_p%0d_f%0d: got v=%b d=%h l=%b rdy=%b, want v=1 d=%h l=%b rdy=%b",
                   p, k, ia.flit.valid, ia.flit.data, ia.flit.last, a_ready,
                   exp_d, exp_l, exp_r);
        end else $display("b2b_p%0d_f%0d: ch%0d d=%h", p, k, g, ia.flit.data);
        @(negedge clk);
      end
    end
    a_valid = 2'b00;
  endtask

  task automatic test_overflow;
    logic [15:0] exp_d [3] = '{16'h1234, 16'h8955, 16'h8007};
    @(negedge clk);
    a_data  = 64'h0000_0000_0000_0007;
    a_ovf   = 2'b01;
    a_valid = 2'b01;
    ia.ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1;
      vectors++;
      if (ia.flit.valid !== 1'b1 || ia.flit.data !== exp_d[k] ||
          ia.flit.last !== 1'(k == 2) || a_ready !== ((k == 2) ? 2'b01 : 2'b00)) begin
        miscompares++;
        $display("FAIL ovf_flit%0d: got v=%b d=%h l=%b rdy=%b, want v=1 d=%h l=%b rdy=%b",
                 k, ia.flit.valid, ia.flit.data, ia.flit.last, a_ready,
                 exp_d[k], (k == 2), (k == 2) ? 2'b01 : 2'b00);
      end else $display("ovf_flit%0d: d=%h", k, ia.flit.data);
      @(negedge clk);
    end
    a_valid = 2'b00;
    a_ovf   = 2'b00;
  endtask

  task automatic test_stall;
    logic        rdy   [7] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    logic [15:0] exp_d [7] = '{16'h1234, 16'h9155, 16'hF00D, 16'hF00D, 16'hF00D,
                              16'hCAFE, 16'hCAFE};
    logic        exp_l;
    logic [1:0]  exp_r;
    @(negedge clk);
    a_data  = 64'hCAFE_F00D_0000_0000;
    a_valid = 2'b10;
    for (int k = 0; k < 7; k++) begin
      ia.ready = rdy[k];
      exp_l = (k >= 5);
      exp_r = (k == 6) ? 2'b10 : 2'b00;
      #1;
      vectors++;
      if (ia.flit.valid !== 1'b1 || ia.flit.data !== exp_d[k] ||
          ia.flit.last !== exp_l || a_ready !== exp_r) begin
        miscompares++;
        $display("FAIL stall_cyc%0d: got v=%b d=%h l=%b rdy=%b, want v=1 d=%h l=%b rdy=%b",
                 k, ia.flit.valid, ia.flit.data, ia.flit.last, a_ready,
                 exp_d[k], exp_l, exp_r);
      end else $display("stall_cyc%0d: ready=%b d=%h", k, rdy[k], ia.flit.data);
      @(negedge clk);
    end
    a_valid  = 2'b00;
    ia.ready = 1'b1;
  endtask

  task automatic test_reset_mid;
    logic [15:0] exp_d [4] = '{16'h1234, 16'h8155, 16'h66BB, 16'h55AA};
    @(negedge clk);
    a_data  = 64'h0000_0000_55AA_66BB;
    a_valid = 2'b01;
    ia.ready = 1'b1;
    for (int k = 0; k < 2; k++) begin
      #1;
      vectors++;
      if (ia.flit.data !== exp_d[k] || ia.flit.valid !== 1'b1) begin
        miscompares++;
        $display("FAIL rmid_pre%0d: got v=%b d=%h, want v=1 d=%h",
                 k, ia.flit.valid, ia.flit.data, exp_d[k]);
      end else $display("rmid_pre%0d: d=%h", k, ia.flit.data);
      @(negedge clk);
    end
    rst_n = 1'b0;
    #1;
    vectors++;
    if (ia.flit.valid !== 1'b0 || ia.flit.last !== 1'b0 || a_ready !== 2'b00) begin
      miscompares++;
      $display("FAIL rmid_reset: got v=%b l=%b rdy=%b, want 0 0 00",
               ia.flit.valid, ia.flit.last, a_ready);
    end else $display("rmid_reset: packet truncated");
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #1;
      vectors++;
      if (ia.flit.valid !== 1'b1 || ia.flit.data !== exp_d[k] ||
          ia.flit.last !== 1'(k == 3) || a_ready !== ((k == 3) ? 2'b01 : 2'b00)) begin
        miscompares++;
        $display("FAIL rmid_resend%0d: got v=%b d=%h l=%b rdy=%b, want v=1 d=%h l=%b rdy=%b",
                 k, ia.flit.valid, ia.flit.data, ia.flit.last, a_ready,
                 exp_d[k], (k == 3), (k == 3) ? 2'b01 : 2'b00);
      end else $display("rmid_resend%0d: d=%h", k, ia.flit.data);
      @(negedge clk);
    end
    a_valid = 2'b00;
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst_n       = 1'b0;
    a_data      = '0;
    a_ovf       = 2'b00;
    a_valid     = 2'b00;
    b_data      = '0;
    b_ovf       = 2'b00;
    b_valid     = 2'b00;
    ia.ready    = 1'b1;
    ib.ready    = 1'b1;

    test_reset();
    test_single();
    test_width20();
    test_back_to_back();
    test_overflow();
    test_stall();
    test_reset_mid();

    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
